// File: rtl/pkt_ingress_writer_pkg.sv
// ----------------------------------------------------------------------------
// pkt_ingress_writer_pkg
// Shared packet-buffer constants and record types used by the ingress writer
// and its neighbours (emptylist, data mover, metadata consumer).
//   PKT_NUM / PKT_AWIDTH   : number of packet slots and pktID width
//   FLIT_SHIFT             : log2 of buffer slots per packet (address shift)
//   PKTBUF_AWIDTH          : packet buffer word address width
//   flit_t                 : one buffer word {data, sop, eop, empty}
//   metadata_t             : per-packet record {pkt_id, flits, len, pkt_flags}
//   PKT_ETH/PKT_PCIE/PKT_DROP : pkt_flags encodings
// ----------------------------------------------------------------------------
package pkt_ingress_writer_pkg;

    localparam int unsigned PKT_NUM       = 64;
    localparam int unsigned PKT_AWIDTH    = $clog2(PKT_NUM);
    localparam int unsigned FLIT_SHIFT    = 5;
    localparam int unsigned PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_SHIFT;
    localparam int unsigned FLIT_DWIDTH   = 512;
    localparam int unsigned EMPTY_WIDTH   = 6;
    localparam int unsigned LEN_WIDTH     = 16;

    typedef logic [2:0] pkt_flags_t;

    localparam pkt_flags_t PKT_ETH  = 3'b001;
    localparam pkt_flags_t PKT_PCIE = 3'b010;
    localparam pkt_flags_t PKT_DROP = 3'b100;

    typedef struct packed {
        logic [FLIT_DWIDTH-1:0] data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
    } flit_t;

    typedef struct packed {
        logic [PKT_AWIDTH-1:0] pkt_id;
        logic [FLIT_SHIFT-1:0] flits;
        logic [LEN_WIDTH-1:0]  len;
        pkt_flags_t            pkt_flags;
    } metadata_t;

    // Buffer word address of slot idx within packet id.
    function automatic logic [PKTBUF_AWIDTH-1:0] pktbuf_addr(
        input logic [PKT_AWIDTH-1:0] id,
        input logic [FLIT_SHIFT-1:0] idx
    );
        return {id, idx};
    endfunction

endpackage

// File: rtl/pkt_ingress_writer.sv
// ----------------------------------------------------------------------------
// pkt_ingress_writer
// Takes the Ethernet RX flit stream, tags each packet with a pktID prefetched
// from the packet emptylist, writes its flits into the packet buffer at
// (pktID << 5) + flit index and, after the last flit, hands one metadata_t
// record to the downstream metadata consumer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_sop/eop/valid/data/empty, in_ready   RX flit stream (accept = valid & ready)
//   emptylist_out_data/valid, emptylist_out_ready   free pktID source (pop)
//   pkt_buffer_address/write/writedata      registered buffer write port
//   meta_valid/meta_data, meta_ready        metadata record handshake
//   stat_pkt_cnt, stat_drop_cnt             packets emitted / dropped
//
// Build option: define INGRESS_STATS_EN to enable the statistics counters;
// when undefined both stat outputs are tied to zero.
//
// MAX_FLITS must equal 1 << FLIT_SHIFT so slots line up with the address shift.
// ----------------------------------------------------------------------------
module pkt_ingress_writer
    import pkt_ingress_writer_pkg::*;
#(
    parameter int unsigned MAX_FLITS     = 32,
    parameter pkt_flags_t  DEFAULT_FLAGS = PKT_PCIE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic                     in_valid,
    input  logic [FLIT_DWIDTH-1:0]   in_data,
    input  logic [EMPTY_WIDTH-1:0]   in_empty,
    output logic                     in_ready,
    input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
    input  logic                     emptylist_out_valid,
    output logic                     emptylist_out_ready,
    output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
    output logic                     pkt_buffer_write,
    output flit_t                    pkt_buffer_writedata,
    output logic                     meta_valid,
    output metadata_t                meta_data,
    input  logic                     meta_ready,
    output logic [31:0]              stat_pkt_cnt,
    output logic [31:0]              stat_drop_cnt
);

    localparam int unsigned IDX_W = FLIT_SHIFT + 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_FLITS);

    typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_t;

    state_t                 state;
    logic                   id_valid;
    logic [PKT_AWIDTH-1:0]  id_reg;
    logic [PKT_AWIDTH-1:0]  cur_id;
    logic [IDX_W-1:0]       flit_idx;
    logic [LEN_WIDTH-1:0]   len_acc;
    logic                   oversize;

    logic                   accept;
    logic                   pop;
    logic                   meta_fire;
    logic                   in_limit;
    logic                   over_now;
    logic [IDX_W-1:0]       idx_inc;
    logic [LEN_WIDTH-1:0]   len_next;
    logic [LEN_WIDTH-1:0]   len_eop;
    logic [LEN_WIDTH-1:0]   len_single;
    logic [FLIT_SHIFT-1:0]  flits_eop;
    flit_t                  in_flit;

    // A pending, unaccepted metadata record stalls the whole input stream.
    assign in_ready            = !(meta_valid & !meta_ready);
    assign accept              = in_valid & in_ready;
    assign emptylist_out_ready = !id_valid;
    assign pop                 = emptylist_out_valid & !id_valid;
    assign meta_fire           = meta_valid & meta_ready;

    assign in_limit   = flit_idx < MAX_IDX;
    assign over_now   = oversize | !in_limit;
    assign idx_inc    = flit_idx + IDX_W'(1);
    assign len_next   = len_acc + LEN_WIDTH'(64);
    assign len_eop    = len_next - LEN_WIDTH'(in_empty);
    assign len_single = LEN_WIDTH'(64) - LEN_WIDTH'(in_empty);
    // A full (MAX_FLITS) count wraps to 0 in the 5-bit field.
    assign flits_eop  = in_limit ? idx_inc[FLIT_SHIFT-1:0] : '0;

    assign in_flit = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= StIdle;
            id_valid             <= 1'b0;
            id_reg               <= '0;
            cur_id               <= '0;
            flit_idx             <= '0;
            len_acc              <= '0;
            oversize             <= 1'b0;
            pkt_buffer_write     <= 1'b0;
            pkt_buffer_address   <= '0;
            pkt_buffer_writedata <= '0;
            meta_valid           <= 1'b0;
            meta_data            <= '0;
        end else begin
            pkt_buffer_write <= 1'b0;
            if (meta_fire) begin
                meta_valid <= 1'b0;
            end
            if (pop) begin
                id_reg   <= emptylist_out_data;
                id_valid <= 1'b1;
            end
            // A flit is only accepted when the metadata slot is free, so an
            // emit below never overwrites an unconsumed record.
            if (accept) begin
                unique case (state)
                    StIdle: begin
                        if (in_sop && id_valid) begin
                            id_valid             <= 1'b0;
                            cur_id               <= id_reg;
                            pkt_buffer_write     <= 1'b1;
                            pkt_buffer_address   <= pktbuf_addr(id_reg, '0);
                            pkt_buffer_writedata <= in_flit;
                            flit_idx             <= IDX_W'(1);
                            len_acc              <= LEN_WIDTH'(64);
                            oversize             <= 1'b0;
                            if (in_eop) begin
                                meta_valid <= 1'b1;
                                meta_data  <= '{pkt_id:    id_reg,
                                               flits:     FLIT_SHIFT'(1),
                                               len:       len_single,
                                               pkt_flags: DEFAULT_FLAGS};
                            end else begin
                                state <= StWrite;
                            end
                        end else if (in_sop && !in_eop) begin
                            state <= StDrop;
                        end
                    end
                    StWrite: begin
                        // sop here is just another middle flit.
                        if (in_limit) begin
                            pkt_buffer_write     <= 1'b1;
                            pkt_buffer_address   <= pktbuf_addr(cur_id,
                                                               flit_idx[FLIT_SHIFT-1:0]);
                            pkt_buffer_writedata <= in_flit;
                            flit_idx             <= idx_inc;
                        end else begin
                            oversize <= 1'b1;
                        end
                        len_acc <= len_next;
                        if (in_eop) begin
                            meta_valid <= 1'b1;
                            meta_data  <= '{pkt_id:    cur_id,
                                           flits:     flits_eop,
                                           len:       len_eop,
                                           pkt_flags: over_now ? PKT_DROP : DEFAULT_FLAGS};
                            state      <= StIdle;
                        end
                    end
                    StDrop: begin
                        if (in_eop) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef INGRESS_STATS_EN
    logic        drop_evt;
    logic        pkt_evt;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    // Drops: sop with no pktID, or an oversize packet reaching its eop.
    assign drop_evt = accept & (((state == StIdle) & in_sop & !id_valid) |
                                ((state == StWrite) & in_eop & over_now));
    assign pkt_evt  = meta_fire & (meta_data.pkt_flags != PKT_DROP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_evt) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (drop_evt) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = pkt_cnt;
    assign stat_drop_cnt = drop_cnt;
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule
